// File: rtl/layer_ctrl_pkg.sv
// Shared types and helpers for the layer sequencer.
//   state_t : sequencer phases FILL -> RST -> LOAD -> COMPUTE -> DRAIN
//   cnt_w   : width of a counter that must reach n (inclusive)
package layer_ctrl_pkg;

  typedef enum logic [2:0] {FILL, RST, LOAD, COMPUTE, DRAIN} state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/layer_sequencer_word_buffer.sv
// word_buffer: SIZE x DEPTH register file, one synchronous write port and
// one asynchronous read port. Contents are never cleared.
//   i_clk            clock
//   i_we/i_waddr/i_wdata  write port (rising edge)
//   i_raddr -> o_rdata    combinational read
module word_buffer
  import layer_ctrl_pkg::*;
#(
  parameter  int SIZE  = 3,
  parameter  int DEPTH = 16,
  localparam int AW    = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [DEPTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [DEPTH-1:0] o_rdata
);

  logic [DEPTH-1:0] r_mem [SIZE];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: collects SIZE words from an input stream, replays them
// back-to-back into a non-stallable layer (plus LAT zero words to fill its
// pipeline), captures SIZE results and streams them out.
//   clk, rst          clock, async active-high reset
//   flush             synchronous abort back to FILL
//   in_valid/in_data/in_ready     input stream
//   layer_rst/input_select/layer_x/layer_y  layer interface
//   out_valid/out_data/out_ready  output stream
//   busy, frame_done  status
module layer_sequencer
  import layer_ctrl_pkg::*;
#(
  parameter int SIZE  = 3,
  parameter int DEPTH = 16,
  parameter int LAT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [DEPTH-1:0] in_data,
  output logic             in_ready,
  output logic             layer_rst,
  output logic             input_select,
  output logic [DEPTH-1:0] layer_x,
  input  logic [DEPTH-1:0] layer_y,
  output logic             out_valid,
  output logic [DEPTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = cnt_w(SIZE + LAT);
  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] SIZE_C    = CW'(SIZE);
  localparam logic [CW-1:0] SIZE_LAST = CW'(SIZE - 1);
  localparam logic [CW-1:0] LOAD_LAST = CW'(SIZE + LAT - 1);

  state_t           r_state, w_nxt_state;
  // One counter serves every phase (k, j, c, m); it is cleared on each exit.
  logic [CW-1:0]    r_cnt, w_nxt_cnt;
  logic             w_in_hs, w_out_hs, w_ib_we, w_rb_we, w_drain_last;
  logic [DEPTH-1:0] w_ib_rdata, w_rb_rdata, w_out_nxt;

  logic             r_layer_rst, r_input_select, r_busy, r_frame_done;
  logic [DEPTH-1:0] r_layer_x, r_out_data;

  // rst gate keeps in_ready low while held, since r_state already reads FILL.
  assign in_ready  = !rst && (r_state == FILL) && !flush;
  assign out_valid = (r_state == DRAIN) && !flush;
  assign w_in_hs   = in_valid && in_ready;
  assign w_out_hs  = out_valid && out_ready;

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_cnt    = r_cnt;
    w_ib_we      = 1'b0;
    w_rb_we      = 1'b0;
    w_drain_last = 1'b0;
    case (r_state)
      FILL: begin
        if (w_in_hs) begin
          w_ib_we = 1'b1;
          if (r_cnt == SIZE_LAST) begin
            w_nxt_state = RST;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_cnt = r_cnt + 1'b1;
          end
        end
      end
      RST: begin
        w_nxt_state = LOAD;
        w_nxt_cnt   = '0;
      end
      LOAD: begin
        if (r_cnt == LOAD_LAST) begin
          w_nxt_state = COMPUTE;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      COMPUTE: begin
        w_rb_we = !flush;
        if (r_cnt == SIZE_LAST) begin
          w_nxt_state = DRAIN;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (w_out_hs) begin
          if (r_cnt == SIZE_LAST) begin
            w_nxt_state  = FILL;
            w_nxt_cnt    = '0;
            w_drain_last = 1'b1;
          end else begin
            w_nxt_cnt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_nxt_state = FILL;
        w_nxt_cnt   = '0;
      end
    endcase
    if (flush) begin
      w_nxt_state = FILL;
      w_nxt_cnt   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
    end
  end

  // Both buffers are read at the next-cycle index so registered outputs line
  // up with the state they belong to.
  word_buffer #(.SIZE(SIZE), .DEPTH(DEPTH)) u_ibuf (
    .i_clk   (clk),
    .i_we    (w_ib_we),
    .i_waddr (r_cnt[AW-1:0]),
    .i_wdata (in_data),
    .i_raddr (w_nxt_cnt[AW-1:0]),
    .o_rdata (w_ib_rdata)
  );

  word_buffer #(.SIZE(SIZE), .DEPTH(DEPTH)) u_rbuf (
    .i_clk   (clk),
    .i_we    (w_rb_we),
    .i_waddr (r_cnt[AW-1:0]),
    .i_wdata (layer_y),
    .i_raddr (w_nxt_cnt[AW-1:0]),
    .o_rdata (w_rb_rdata)
  );

  // Bypass covers SIZE=1, where the first result is written on the same edge
  // that enters DRAIN.
  assign w_out_nxt = (w_rb_we && (r_cnt[AW-1:0] == w_nxt_cnt[AW-1:0])) ? layer_y : w_rb_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_layer_rst    <= 1'b1;
      r_input_select <= 1'b1;
      r_layer_x      <= '0;
      r_out_data     <= '0;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_layer_rst    <= (w_nxt_state == FILL) || (w_nxt_state == RST);
      r_input_select <= (w_nxt_state != COMPUTE);
      r_layer_x      <= ((w_nxt_state == LOAD) && (w_nxt_cnt < SIZE_C)) ? w_ib_rdata : '0;
      if (w_nxt_state == DRAIN) r_out_data <= w_out_nxt;
      r_busy         <= (w_nxt_state != FILL);
      r_frame_done   <= w_drain_last;
    end
  end

  assign layer_rst    = r_layer_rst;
  assign input_select = r_input_select;
  assign layer_x      = r_layer_x;
  assign out_data     = r_out_data;
  assign busy         = r_busy;
  assign frame_done   = r_frame_done;

endmodule
